msk_tof_operand_feeder: RTL and testbench

Issue stage placed directly upstream of the swapped-input HPC3 Toffoli AND gadget. It accepts one masked operand triple (a, b, c) per handshake and registers it onto the gadget's ina/inb/inc ports. One cycle later it re-presents the same b sharing on inb_prev. It also supplies fresh gadget randomness from an internal seeded LFSR bank, and flags the cycle on which the gadget output is valid.

---
 rtl/msk_tof_operand_feeder.sv | 91 +++++++++
 tb/tb_msk_tof_operand_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/msk_tof_operand_feeder.sv
// msk_tof_operand_feeder: issue stage registering masked operand triples and fresh LFSR randomness into the HPC3 Toffoli gadget.
module msk_tof_operand_feeder #(
  parameter int d = 2,
  parameter int RNDW = d * (d - 1),
  parameter int OPS_LIMIT = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_start,
  input  logic            seed_bit,
  input  logic            seed_valid,
  output logic            seeded,
  input  logic [d-1:0]    a_sh,
  input  logic [d-1:0]    b_sh,
  input  logic [d-1:0]    c_sh,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [d-1:0]    ina,
  output logic [d-1:0]    inb,
  output logic [d-1:0]    inc,
  output logic [d-1:0]    inb_prev,
  output logic [RNDW-1:0] rnd,
`ifdef MSK_FEEDER_RESEED_REQ_EN
  output logic            reseed_req,
`endif
  output logic            out_valid
);
  localparam int N = 31 * RNDW;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {UNSEEDED, SEED, RUN} state_t;
  state_t state, state_nx;
  logic [N-1:0] chain, chain_shift, chain_load, chain_step;
  logic [RNDW-1:0] rnd_nx;
  logic [CW-1:0] cnt;
  logic acc, issue, seed_shift, seed_done, limit_hit;
`ifdef MSK_FEEDER_RESEED_REQ_EN
  logic [15:0] ops;
  assign limit_hit = ops >= 16'(OPS_LIMIT);
  assign reseed_req = limit_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ops <= '0;
    else if (seed_start) ops <= '0;
    else if (acc) ops <= ops + 16'd1;
`else
  assign limit_hit = 1'b0;
`endif
  assign seeded = state == RUN;
  assign in_ready = seeded & ~seed_start & ~limit_hit;
  assign acc = in_valid & in_ready;
  assign seed_shift = state == SEED && seed_valid && !seed_start;
  assign seed_done = seed_shift && cnt == CW'(N - 1);
  assign chain_shift = {seed_bit, chain[N-1:1]};
  for (genvar i = 0; i < RNDW; i++) begin : g_lane
    logic [30:0] sh, st;
    assign sh = chain_shift[31*i +: 31];
    assign st = chain[31*i +: 31];
    assign chain_load[31*i +: 31] = (|sh) ? sh : 31'h1;
    assign chain_step[31*i +: 31] = {st[29:0], st[30] ^ st[27]};
    assign rnd_nx[i] = st[30] ^ st[27];
  end
  always_comb state_nx = seed_start ? SEED : seed_done ? RUN : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= UNSEEDED;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (seed_start) cnt <= '0;
    else if (seed_shift) cnt <= cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= '0;
    else if (seed_shift) chain <= seed_done ? chain_load : chain_shift;
    else if (acc) chain <= chain_step;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ina <= '0;
      inb <= '0;
      inc <= '0;
      inb_prev <= '0;
      rnd <= '0;
      issue <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ina <= acc ? a_sh : '0;
      inb <= acc ? b_sh : '0;
      inc <= acc ? c_sh : '0;
      inb_prev <= inb;
      rnd <= acc ? rnd_nx : rnd;
      issue <= acc;
      out_valid <= issue;
    end
endmodule

// File: tb/tb_msk_tof_operand_feeder.sv
// tb_msk_tof_operand_feeder: randomized directed bench against a behavioural model of the feeder.
module tb_msk_tof_operand_feeder;
   localparam int N = 62;
   localparam int LIM = 3;
`ifdef MSK_FEEDER_RESEED_REQ_EN
   localparam bit RQ = 1'b1;
`else
   localparam bit RQ = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic seed_start = 1'b0, seed_bit = 1'b0, seed_valid = 1'b0, in_valid = 1'b0;
   logic [1:0] a_sh = '0, b_sh = '0, c_sh = '0;
   logic seeded, in_ready, out_valid;
   logic [1:0] ina, inb, inc, inb_prev, rnd;
`ifdef MSK_FEEDER_RESEED_REQ_EN
   logic reseed_req;
`endif
   int errors = 0, checks = 0;
   int mst = 0, mcnt = 0, mops = 0;
   bit mbits [N];
   logic [30:0] ml [2];
   logic [1:0] e_ina = '0, e_inb = '0, e_inc = '0, e_prev = '0, e_rnd = '0;
   bit e_issue = 1'b0, e_ov = 1'b0;

   msk_tof_operand_feeder #(.d(2), .RNDW(2), .OPS_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .seed_start(seed_start), .seed_bit(seed_bit),
      .seed_valid(seed_valid), .seeded(seeded), .a_sh(a_sh), .b_sh(b_sh), .c_sh(c_sh),
      .in_valid(in_valid), .in_ready(in_ready), .ina(ina), .inb(inb), .inc(inc),
      .inb_prev(inb_prev), .rnd(rnd),
`ifdef MSK_FEEDER_RESEED_REQ_EN
      .reseed_req(reseed_req),
`endif
      .out_valid(out_valid));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [30:0] lstep(input logic [30:0] s);
      return (s << 1) | 31'(((s >> 30) ^ (s >> 27)) & 31'd1);
   endfunction

   task automatic chk_out();
      chk("seeded", seeded, mst == 2);
      chk("ina", ina, e_ina);
      chk("inb", inb, e_inb);
      chk("inc", inc, e_inc);
      chk("inb_prev", inb_prev, e_prev);
      chk("rnd", rnd, e_rnd);
      chk("out_valid", out_valid, e_ov);
`ifdef MSK_FEEDER_RESEED_REQ_EN
      chk("reseed_req", reseed_req, mops >= LIM);
`endif
   endtask

   task automatic model_reset();
      mst = 0; mcnt = 0; mops = 0;
      e_ina = '0; e_inb = '0; e_inc = '0; e_prev = '0; e_rnd = '0;
      e_issue = 1'b0; e_ov = 1'b0;
   endtask

   task automatic step(input bit ss, input bit sv, input bit sb, input bit iv,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      bit lim, acc;
      logic [30:0] v;
      @(negedge clk);
      seed_start = ss; seed_valid = sv; seed_bit = sb; in_valid = iv;
      a_sh = a; b_sh = b; c_sh = c;
      lim = RQ && mops >= LIM;
      acc = mst == 2 && !ss && !lim && iv;
      #1;
      chk("in_ready", in_ready, mst == 2 && !ss && !lim);
      @(posedge clk);
      e_prev = e_inb;
      e_ov = e_issue;
      e_issue = acc;
      e_ina = acc ? a : 2'b00;
      e_inb = acc ? b : 2'b00;
      e_inc = acc ? c : 2'b00;
      if (acc) begin
         mops++;
         for (int i = 0; i < 2; i++) begin
            ml[i] = lstep(ml[i]);
            e_rnd[i] = ml[i][0];
         end
      end
      if (ss) begin
         mst = 1; mcnt = 0; mops = 0;
      end else if (mst == 1 && sv) begin
         mbits[mcnt] = sb;
         mcnt++;
         if (mcnt == N) begin
            for (int i = 0; i < 2; i++) begin
               v = '0;
               for (int j = 0; j < 31; j++) v = v | (31'(mbits[31*i+j]) << j);
               ml[i] = (v == 0) ? 31'd1 : v;
            end
            mst = 2;
         end
      end
      #1;
      chk_out();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      step(0, 0, 0, 1, a, b, c);
   endtask

   task automatic load(input bit zero);
      step(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < N;) begin
         if ($urandom_range(3) == 0) step(0, 0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
         else begin
            step(0, 1, zero ? 1'b0 : 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            k++;
         end
      end
   endtask

   initial begin
      #12;
      chk_out();
      chk("in_ready_rst", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      step(1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < 10; k++) step(0, 1, 1'($urandom), 0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk_out();
      chk("in_ready_rst2", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      load(1);
      chk("seeded_zero", seeded, 1);
      op(2'b01, 2'b10, 2'b11);
      chk("first_rnd", rnd, 0);
      chk("inb_t1", inb, 2'b10);
      idle();
      chk("inb_prev_t2", inb_prev, 2'b10);
      chk("out_valid_t2", out_valid, 1);
      chk("ina_t2_zero", ina, 0);
      idle();
      load(1);
      for (int k = 0; k < 4; k++) op(2'($urandom), 2'($urandom), 2'($urandom));
      idle(); idle();
      load(0);
      op(2'b11, 2'b01, 2'b10);
      step(1, 0, 0, 1, 2'b01, 2'b01, 2'b01);
      idle(); idle();
      load(0);
      for (int k = 0; k < 40; k++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      load(0);
      for (int k = 0; k < 5; k++) op(2'($urandom), 2'($urandom), 2'($urandom));
      load(0);
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
